// File: rtl/debounce_bank.sv
// Multi-channel button debouncer with press/release edge pulses and long-press detection.
// Define DEBOUNCE_BANK_REPEAT_EN to add periodic long_press repeats while a button stays held.
module debounce_bank #(
    parameter int                  CHANNELS      = 4,
    parameter int                  COUNT_BITS    = 21,
    parameter int                  HOLD_BITS     = 25,
    parameter logic [CHANNELS-1:0] DEFAULT_VALUE = {CHANNELS{1'b0}},
    parameter logic                ACTIVE_LEVEL  = 1'b0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] debounced,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] released,
    output logic [CHANNELS-1:0] long_press
);

    localparam logic [COUNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [COUNT_BITS-1:0] CNT_ONE  = 1;
    localparam logic [HOLD_BITS-1:0]  HOLD_MAX = '1;
    localparam logic [HOLD_BITS-1:0]  HOLD_ONE = 1;

    logic [CHANNELS-1:0]                 sync1_q, sync2_q;
    logic [CHANNELS-1:0][COUNT_BITS-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0]                 deb_q, deb_d;
    logic [CHANNELS-1:0]                 pressed_q, pressed_d;
    logic [CHANNELS-1:0]                 released_q, released_d;
    logic [CHANNELS-1:0][HOLD_BITS-1:0]  hold_q, hold_d;
    logic [CHANNELS-1:0]                 lp_done_q, lp_done_d;
    logic [CHANNELS-1:0]                 long_press_q, long_press_d;
    logic [CHANNELS-1:0]                 active, stay;

`ifdef DEBOUNCE_BANK_REPEAT_EN
    localparam logic [HOLD_BITS-3:0] REP_MAX = '1;
    localparam logic [HOLD_BITS-3:0] REP_ONE = 1;

    logic [CHANNELS-1:0][HOLD_BITS-3:0] rep_q, rep_d;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= DEFAULT_VALUE;
            sync2_q <= DEFAULT_VALUE;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
        end
    end

    // Settle counter: any disagreement must persist for a full count-down before it is accepted.
    always_comb begin
        cnt_d      = cnt_q;
        deb_d      = deb_q;
        pressed_d  = '0;
        released_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = CNT_MAX;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else begin
                cnt_d[i] = CNT_MAX;
                deb_d[i] = sync2_q[i];
                if (sync2_q[i] == ACTIVE_LEVEL) begin
                    pressed_d[i] = 1'b1;
                end else begin
                    released_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= {CHANNELS{CNT_MAX}};
            deb_q      <= DEFAULT_VALUE;
            pressed_q  <= '0;
            released_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    // stay masks out the edge on which the channel is being released, so no late long_press can fire.
    always_comb begin
        active = ~(deb_q ^ {CHANNELS{ACTIVE_LEVEL}});
        stay   = active & ~(deb_d ^ {CHANNELS{ACTIVE_LEVEL}});
    end

    // The first long_press follows the edge on which the hold count saturates; lp_done arms the repeats.
    always_comb begin
        hold_d       = hold_q;
        lp_done_d    = lp_done_q;
        long_press_d = '0;
`ifdef DEBOUNCE_BANK_REPEAT_EN
        rep_d        = rep_q;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            if (active[i]) begin
                if (hold_q[i] != HOLD_MAX) begin
                    hold_d[i] = hold_q[i] + HOLD_ONE;
                end
            end else begin
                hold_d[i] = '0;
            end

            if (stay[i] && (hold_q[i] == HOLD_MAX) && !lp_done_q[i]) begin
                long_press_d[i] = 1'b1;
            end

`ifdef DEBOUNCE_BANK_REPEAT_EN
            if (active[i] && lp_done_q[i]) begin
                rep_d[i] = rep_q[i] + REP_ONE;
            end else begin
                rep_d[i] = '0;
            end
            if (stay[i] && lp_done_q[i] && (rep_q[i] == REP_MAX)) begin
                long_press_d[i] = 1'b1;
            end
`endif

            if (active[i]) begin
                lp_done_d[i] = lp_done_q[i] | long_press_d[i];
            end else begin
                lp_done_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_q       <= '0;
            lp_done_q    <= '0;
            long_press_q <= '0;
        end else begin
            hold_q       <= hold_d;
            lp_done_q    <= lp_done_d;
            long_press_q <= long_press_d;
        end
    end

`ifdef DEBOUNCE_BANK_REPEAT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    assign debounced  = deb_q;
    assign pressed    = pressed_q;
    assign released   = released_q;
    assign long_press = long_press_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: expected pulse events are queued as stimulus is applied
// and matched against the outputs by a monitor on the falling clock edge.
module tb_debounce_bank;

    logic       clock;
    logic       reset_n;
    logic [3:0] button;
    logic [3:0] debounced;
    logic [3:0] pressed;
    logic [3:0] released;
    logic [3:0] long_press;

    int          checks = 0;
    int          errors = 0;
    int unsigned edge_n = 0;
    int unsigned n0;

    typedef struct {
        int unsigned at;
        logic [3:0]  pr;
        logic [3:0]  rl;
        logic [3:0]  lp;
    } ev_t;

    ev_t exp_q[$];

    debounce_bank #(
        .CHANNELS     (4),
        .COUNT_BITS   (4),
        .HOLD_BITS    (6),
        .DEFAULT_VALUE(4'hF),
        .ACTIVE_LEVEL (1'b0)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .button    (button),
        .debounced (debounced),
        .pressed   (pressed),
        .released  (released),
        .long_press(long_press)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input int unsigned at, input logic [3:0] pr, input logic [3:0] rl,
                        input logic [3:0] lp);
        ev_t e;
        e.at = at;
        e.pr = pr;
        e.rl = rl;
        e.lp = lp;
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin : monitor
        ev_t ev;
        if (reset_n === 1'b1 && (|pressed || |released || |long_press)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {20'd0, pressed, released, long_press}, 32'd0);
            end else begin
                ev = exp_q.pop_front();
                check("pulse_edge", edge_n, ev.at);
                check("pulse_vec", {20'd0, pressed, released, long_press},
                      {20'd0, ev.pr, ev.rl, ev.lp});
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        button  = 4'hF;
        wait_edges(3);
        check("rst_debounced", {28'd0, debounced}, 32'hF);
        check("rst_pulses", {20'd0, pressed, released, long_press}, 32'd0);
        reset_n = 1'b1;

        // idle: inputs equal to the reset value, nothing may happen
        wait_edges(200);
        check("idle_debounced", {28'd0, debounced}, 32'hF);

        // channel 0: press settles on the 18th edge, release 30 edges later
        n0 = edge_n;
        button[0] = 1'b0;
        push(n0 + 18, 4'b0001, 4'b0000, 4'b0000);
        wait_edges(17);
        check("ch0_before_settle", {28'd0, debounced}, 32'hF);
        wait_edges(1);
        check("ch0_settled", {28'd0, debounced}, 32'hE);
        wait_edges(12);
        n0 = edge_n;
        button[0] = 1'b1;
        push(n0 + 18, 4'b0000, 4'b0001, 4'b0000);
        wait_edges(17);
        check("ch0_before_release", {28'd0, debounced}, 32'hE);
        wait_edges(1);
        check("ch0_released", {28'd0, debounced}, 32'hF);

        // channel 1: 10-clock glitch is rejected
        button[1] = 1'b0;
        wait_edges(10);
        button[1] = 1'b1;
        wait_edges(40);
        check("ch1_glitch", {28'd0, debounced}, 32'hF);

        // channel 2: long hold produces long_press 64 edges after pressed
        n0 = edge_n;
        button[2] = 1'b0;
        push(n0 + 18, 4'b0100, 4'b0000, 4'b0000);
        push(n0 + 82, 4'b0000, 4'b0000, 4'b0100);
`ifdef DEBOUNCE_BANK_REPEAT_EN
        push(n0 + 98, 4'b0000, 4'b0000, 4'b0100);
        push(n0 + 114, 4'b0000, 4'b0000, 4'b0100);
`endif
        push(n0 + 118, 4'b0000, 4'b0100, 4'b0000);
        wait_edges(50);
        check("ch2_held", {28'd0, debounced}, 32'hB);
        wait_edges(50);
        button[2] = 1'b1;
        wait_edges(40);
        check("ch2_released", {28'd0, debounced}, 32'hF);

        // channel 3: reset in the middle of settling discards progress
        button[3] = 1'b0;
        wait_edges(12);
        reset_n = 1'b0;
        #1;
        check("midrst_debounced", {28'd0, debounced}, 32'hF);
        check("midrst_pulses", {20'd0, pressed, released, long_press}, 32'd0);
        wait_edges(3);
        check("midrst_hold", {28'd0, debounced}, 32'hF);
        reset_n = 1'b1;
        n0 = edge_n;
        push(n0 + 18, 4'b1000, 4'b0000, 4'b0000);
        wait_edges(17);
        check("ch3_before_settle", {28'd0, debounced}, 32'hF);
        wait_edges(1);
        check("ch3_settled", {28'd0, debounced}, 32'h7);
        wait_edges(12);
        n0 = edge_n;
        button[3] = 1'b1;
        push(n0 + 18, 4'b0000, 4'b1000, 4'b0000);
        wait_edges(18);
        check("ch3_released", {28'd0, debounced}, 32'hF);

        wait_edges(20);
        check("events_outstanding", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
